// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Desc     : Shared rv32i encodings: writeback source select and hazard FSM
//            state encoding, plus the load-use match helper.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam logic [1:0] RF_DIN_ALU  = 2'd0;
    localparam logic [1:0] RF_DIN_DM   = 2'd1;
    localparam logic [1:0] RF_DIN_PC4  = 2'd2;
    localparam logic [1:0] RF_DIN_IMM  = 2'd3;

    localparam logic [1:0] HZ_BOOT     = 2'd0;
    localparam logic [1:0] HZ_RUN      = 2'd1;
    localparam logic [1:0] HZ_MEM_WAIT = 2'd2;

    // A load in EX feeding a source that ID really reads; x0 is never a hazard.
    function automatic logic load_use_hit(
        input logic       ex_we,
        input logic [1:0] ex_din_sel,
        input logic [4:0] ex_waddr,
        input logic [4:0] rs1,
        input logic       rs1_used,
        input logic [4:0] rs2,
        input logic       rs2_used
    );
        logic w_is_load;
        w_is_load = ex_we && (ex_din_sel == RF_DIN_DM) && (ex_waddr != 5'd0);
        return w_is_load && ((rs1_used && (rs1 == ex_waddr)) ||
                             (rs2_used && (rs2 == ex_waddr)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : hazard_perf_cnt
// Desc     : Stall and flush cycle counters for the hazard controller;
//            both wrap modulo 2^CNT_W.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_stall_inc,
    input  logic             i_flush_inc,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (i_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Desc     : Five-stage rv32i hazard/stall controller: post-reset hold,
//            memory stall, redirect flush, load-use bubble, MEM watchdog.
// Optional : define HAZARD_PERF_CNT_EN to build the stall/flush counters;
//            otherwise stall_cnt/flush_cnt read as 0.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES = 4,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rf_raddr_rs1,
    input  logic [4:0]       id_rf_raddr_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rf_waddr,
    input  logic             ex_rf_we,
    input  logic [1:0]       ex_rf_din_sel,
    input  logic             ex_redirect,
    input  logic             mem_dm_req,
    input  logic             mem_dm_ready,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             id_ex_enable,
    output logic             ex_mem_enable,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int c_hold_w = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam int c_wd_w   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RESET_HOLD_CYCLES - 1);
    localparam logic [c_wd_w-1:0]   c_wd_max    = c_wd_w'(MEM_TIMEOUT);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_hold_w-1:0] r_hold;
    logic [c_wd_w-1:0]   r_wd;
    logic [c_wd_w-1:0]   w_wd_next;
    logic                r_err;
    logic                w_mem_stall;
    logic                w_load_use;

    assign w_mem_stall = mem_dm_req && !mem_dm_ready;
    assign w_load_use  = load_use_hit(ex_rf_we, ex_rf_din_sel, ex_rf_waddr,
                                      id_rf_raddr_rs1, id_rs1_used,
                                      id_rf_raddr_rs2, id_rs2_used);

    always_comb begin
        w_state_next  = r_state;
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_flush  = 1'b0;
        case (r_state)
            HZ_RUN, HZ_MEM_WAIT: begin
                w_state_next = w_mem_stall ? HZ_MEM_WAIT : HZ_RUN;
                // Memory stall outranks redirect: EX is frozen and re-presents it.
                if (w_mem_stall) begin
                    pc_enable     = 1'b0;
                    if_id_enable  = 1'b0;
                    id_ex_enable  = 1'b0;
                    ex_mem_enable = 1'b0;
                    mem_wb_flush  = 1'b1;
                end else if (ex_redirect) begin
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                end else if (w_load_use) begin
                    pc_enable     = 1'b0;
                    if_id_enable  = 1'b0;
                    id_ex_flush   = 1'b1;
                end
            end
            default: begin
                w_state_next  = (r_state == HZ_BOOT && r_hold == c_hold_last) ? HZ_RUN : HZ_BOOT;
                pc_enable     = 1'b0;
                if_id_enable  = 1'b0;
                id_ex_enable  = 1'b0;
                ex_mem_enable = 1'b0;
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                mem_wb_flush  = 1'b1;
            end
        endcase
    end

    // Watchdog counts stalled MEM_WAIT cycles only and saturates at the limit.
    always_comb begin
        w_wd_next = '0;
        if (r_state == HZ_MEM_WAIT && w_mem_stall)
            w_wd_next = (r_wd == c_wd_max) ? r_wd : r_wd + c_wd_w'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= HZ_BOOT;
            r_hold  <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == HZ_BOOT && r_hold != c_hold_last)
                r_hold <= r_hold + c_hold_w'(1);
            r_wd <= w_wd_next;
            if (w_wd_next == c_wd_max)
                r_err <= 1'b1;
        end
    end

    assign mem_timeout_err = r_err;

`ifdef HAZARD_PERF_CNT_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = (r_state != HZ_BOOT) && !pc_enable;
    assign w_flush_inc = (r_state != HZ_BOOT) && (if_id_flush || id_ex_flush);

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rstn        (rstn),
        .i_stall_inc (w_stall_inc),
        .i_flush_inc (w_flush_inc),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Desc     : Directed self-checking bench for hazard_ctrl (hold 4, timeout 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    import rv32i_pkg::*;

    localparam int CNT_W = 32;
    // {pc, if_id, id_ex, ex_mem enables, if_id, id_ex, mem_wb flushes}
    localparam logic [6:0] C_BOOT = 7'b0000_111;
    localparam logic [6:0] C_FREE = 7'b1111_000;
    localparam logic [6:0] C_LU   = 7'b0011_010;
    localparam logic [6:0] C_RDR  = 7'b1111_110;
    localparam logic [6:0] C_MSTL = 7'b0000_001;

    logic             clk = 1'b0;
    logic             rstn;
    logic [4:0]       id_rf_raddr_rs1, id_rf_raddr_rs2, ex_rf_waddr;
    logic             id_rs1_used, id_rs2_used, ex_rf_we, ex_redirect;
    logic [1:0]       ex_rf_din_sel;
    logic             mem_dm_req, mem_dm_ready;
    logic             pc_enable, if_id_enable, id_ex_enable, ex_mem_enable;
    logic             if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       w_ctl;

    int total = 0;
    int bad = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    assign w_ctl = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable,
                    if_id_flush, id_ex_flush, mem_wb_flush};

    hazard_ctrl #(
        .RESET_HOLD_CYCLES (4),
        .MEM_TIMEOUT       (8),
        .CNT_W             (CNT_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .id_rf_raddr_rs1 (id_rf_raddr_rs1),
        .id_rf_raddr_rs2 (id_rf_raddr_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rf_waddr     (ex_rf_waddr),
        .ex_rf_we        (ex_rf_we),
        .ex_rf_din_sel   (ex_rf_din_sel),
        .ex_redirect     (ex_redirect),
        .mem_dm_req      (mem_dm_req),
        .mem_dm_ready    (mem_dm_ready),
        .pc_enable       (pc_enable),
        .if_id_enable    (if_id_enable),
        .id_ex_enable    (id_ex_enable),
        .ex_mem_enable   (ex_mem_enable),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .mem_timeout_err (mem_timeout_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already applied; check the control vector mid-cycle, then advance one edge.
    task automatic step(input string tag, input logic [6:0] exp, input bit boot);
        @(negedge clk);
        chk(tag, {57'd0, w_ctl}, {57'd0, exp});
        if (!boot) begin
            if (!exp[6]) exp_stall++;
            if (exp[2] || exp[1]) exp_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
        chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(exp_flush));
`else
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
        chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
`endif
    endtask

    task automatic clear_inputs();
        id_rf_raddr_rs1 = 5'd0;
        id_rf_raddr_rs2 = 5'd0;
        id_rs1_used     = 1'b0;
        id_rs2_used     = 1'b0;
        ex_rf_waddr     = 5'd0;
        ex_rf_we        = 1'b0;
        ex_rf_din_sel   = RF_DIN_ALU;
        ex_redirect     = 1'b0;
        mem_dm_req      = 1'b0;
        mem_dm_ready    = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        ex_rf_we        = 1'b1;
        ex_rf_din_sel   = RF_DIN_DM;
        ex_rf_waddr     = rd;
        id_rf_raddr_rs1 = rs1;
        id_rs1_used     = u1;
        id_rf_raddr_rs2 = rs2;
        id_rs2_used     = u2;
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ctl", {57'd0, w_ctl}, {57'd0, C_BOOT});
        chk("rst_err", {63'd0, mem_timeout_err}, 64'd0);
        chk_cnt("rst");
        @(posedge clk);
        #1;

        rstn = 1'b1;
        for (int i = 0; i < 4; i++) step("boot_hold", C_BOOT, 1'b1);
        step("run_free", C_FREE, 1'b0);
        chk_cnt("after_boot");

        // lw x5 in EX, add x6,x5,x1 in ID
        set_load(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
        step("lu_rs1", C_LU, 1'b0);
        clear_inputs();
        step("lu_after", C_FREE, 1'b0);
        set_load(5'd0, 5'd0, 1'b1, 5'd1, 1'b1);
        step("lu_x0", C_FREE, 1'b0);
        set_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        step("lu_rs2_unused", C_FREE, 1'b0);
        set_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        step("lu_rs2", C_LU, 1'b0);
        ex_rf_din_sel = RF_DIN_ALU;
        step("alu_no_lu", C_FREE, 1'b0);
        clear_inputs();
        chk_cnt("after_lu");

        ex_redirect = 1'b1;
        step("redirect", C_RDR, 1'b0);
        set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        step("redirect_over_lu", C_RDR, 1'b0);
        clear_inputs();
        step("redirect_after", C_FREE, 1'b0);
        chk_cnt("after_redirect");

        mem_dm_req  = 1'b1;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) step("mstall_over_rdr", C_MSTL, 1'b0);
        mem_dm_ready = 1'b1;
        step("ready_redirect", C_RDR, 1'b0);
        clear_inputs();
        step("mstall_after", C_FREE, 1'b0);
        chk_cnt("after_mstall");

        mem_dm_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            chk("wd_err", {63'd0, mem_timeout_err}, {63'd0, (i == 10)});
            step("wd_stall", C_MSTL, 1'b0);
        end
        mem_dm_ready = 1'b1;
        chk("wd_err_ready", {63'd0, mem_timeout_err}, 64'd1);
        step("wd_ready", C_FREE, 1'b0);
        clear_inputs();
        chk("wd_err_sticky", {63'd0, mem_timeout_err}, 64'd1);
        step("wd_idle", C_FREE, 1'b0);
        chk_cnt("after_wd");

        // reset asserted while in MEM_WAIT
        mem_dm_req = 1'b1;
        step("pre_rst_stall", C_MSTL, 1'b0);
        step("pre_rst_wait", C_MSTL, 1'b0);
        #2;
        rstn = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        #1;
        chk("midrst_ctl", {57'd0, w_ctl}, {57'd0, C_BOOT});
        chk("midrst_err", {63'd0, mem_timeout_err}, 64'd0);
        chk_cnt("midrst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) step("reboot_hold", C_BOOT, 1'b1);
        step("post_rst_stall", C_MSTL, 1'b0);
        mem_dm_ready = 1'b1;
        step("post_rst_ready", C_FREE, 1'b0);
        clear_inputs();
        chk("post_rst_err", {63'd0, mem_timeout_err}, 64'd0);
        chk_cnt("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage rv32i core: the producer of the `enable`/flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It detects load-use hazards, taken branches and jumps, and multi-cycle data-memory accesses. It freezes or bubbles the stage registers accordingly and holds the pipeline for a fixed number of cycles after reset. Registers implement flush as a synchronous clear that takes priority over `enable`.

## Interface
- `RESET_HOLD_CYCLES`, 4: cycles the pipeline stays frozen after reset release; legal range ≥1.
- `MEM_TIMEOUT`, 255: consecutive MEM_WAIT cycles before `mem_timeout_err` sets.
- `CNT_W`, 32: width of the performance counters.
- `clk`  in  1  core clock.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `id_rf_raddr_rs1`, `id_rf_raddr_rs2`  in  5 each  ID source register addresses.
- `id_rs1_used`, `id_rs2_used`  in  1 each  ID instruction actually reads rs1/rs2.
- `ex_rf_waddr`  in  5  EX destination register.
- `ex_rf_we`  in  1  EX writes the register file.
- `ex_rf_din_sel`  in  2  EX writeback source; value `RF_DIN_DM` marks a load.
- `ex_redirect`  in  1  EX branch taken or jump (JAL/JALR).
- `mem_dm_req`  in  1  MEM stage has a data-memory access.
- `mem_dm_ready`  in  1  data memory completes the access this cycle.
- `pc_enable`, `if_id_enable`, `id_ex_enable`, `ex_mem_enable`  out  1 each  register update enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1 each  bubble insertion.
- `mem_timeout_err`  out  1  sticky watchdog flag.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  performance counters.

## Operation
- States: BOOT, RUN, MEM_WAIT.
- BOOT:
  - All enables 0; `if_id_flush`, `id_ex_flush` and `mem_wb_flush` are 1.
  - The hold counter counts up from 0.
  - Move to RUN when hold counter = `RESET_HOLD_CYCLES`-1.
- RUN and MEM_WAIT evaluate the conditions below in priority order; the first match sets the outputs.
  1. Memory stall, `mem_dm_req && !mem_dm_ready`:
     - `pc_enable`, `if_id_enable`, `id_ex_enable` and `ex_mem_enable` are 0.
     - `mem_wb_flush`=1.
     - Next state is MEM_WAIT.
  2. Redirect, `ex_redirect`:
     - All enables 1.
     - `if_id_flush`=1 and `id_ex_flush`=1.
  3. Load-use:
     - Detected when `ex_rf_we && ex_rf_din_sel==RF_DIN_DM && ex_rf_waddr!=0`, and `ex_rf_waddr` equals a used source (rs1 with `id_rs1_used`, or rs2 with `id_rs2_used`).
     - `pc_enable`=0 and `if_id_enable`=0.
     - `id_ex_enable`=1 with `id_ex_flush`=1.
  4. Otherwise: all enables 1, all flushes 0.
- MEM_WAIT returns to RUN in the cycle after `mem_dm_ready` is sampled high. In the ready cycle itself, priority 2–4 apply.
- Watchdog counter:
  - Counts while in MEM_WAIT and clears on leaving it.
  - On reaching `MEM_TIMEOUT`, `mem_timeout_err` sets. It stays set until reset.
  - The FSM keeps waiting after the flag sets.
  - The counter saturates.
- Register x0 never causes a load-use stall.
- A memory stall overrides a concurrent redirect. EX stays frozen, so `ex_redirect` is re-presented after the stall releases.

## Timing
- All control outputs are combinational from the current state and inputs, so they take effect at the next rising edge.
- Load-use costs exactly one bubble.
- Redirect costs two flushed slots, the IF/ID and ID/EX instructions.
- Memory stall lasts N cycles for N low-`mem_dm_ready` cycles.
- Reset: asynchronous. While `rstn`=0:
  - State is BOOT with counter 0.
  - All enables 0 and all flushes 1.
  - `mem_timeout_err`=0, `stall_cnt`=0, `flush_cnt`=0.
- Reset asserted mid-MEM_WAIT aborts the wait immediately.
- After `rstn` rises, the first enabled edge is edge `RESET_HOLD_CYCLES`+1.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `pc_enable`=0 outside BOOT.
  - `flush_cnt` increments on every cycle with `if_id_flush` or `id_ex_flush`=1 outside BOOT.
  - Both counters wrap modulo 2^`CNT_W`.
- Not defined: counter logic is removed, and `stall_cnt`/`flush_cnt` are tied to 0. The ports remain.

## Structure
- Shared package `rv32i_pkg` holds:
  - `RF_DIN_DM`, with `RF_DIN_*` encodings matching the decoder.
  - Hazard FSM state encoding BOOT=2'd0, RUN=2'd1, MEM_WAIT=2'd2.
- Sub-module `hazard_perf_cnt` holds both counters. It is instantiated only under `HAZARD_PERF_CNT_EN`.

## Test plan
- Reset, `RESET_HOLD_CYCLES`=4, then release `rstn`: enables are 0 for 4 edges, then 1. `stall_cnt` remains 0.
- `lw x5` in EX, ID `add x6,x5,x1` with `id_rs1_used`: exactly one cycle of `pc_enable`=0, `if_id_enable`=0, `id_ex_flush`=1, then free run. Same test with `ex_rf_waddr`=0: no stall.
- `ex_redirect`=1 for one cycle: `if_id_flush`=`id_ex_flush`=1 for that cycle, `pc_enable`=1. `flush_cnt` increments by 1 with the macro, stays 0 without.
- `mem_dm_req`=1, `mem_dm_ready` low for 3 cycles with `ex_redirect`=1: freeze for 3 cycles with `mem_wb_flush`=1, then redirect flush in the ready cycle.
- `MEM_TIMEOUT`=8, `mem_dm_ready` held low for 10 cycles: `mem_timeout_err` rises after 8 MEM_WAIT cycles and stays high after ready. Reset mid-wait clears the flag and returns to BOOT.
